// File: rtl/cacheline_mem_arbiter_pkg.sv
// Shared types for the cacheline memory arbiter: FSM state encoding,
// the cacheline type and the byte-offset width of one 32-byte line.
package mp3_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

    typedef logic [255:0] cacheline_t;

    localparam int LINE_OFFSET_W = 5;

endpackage

// File: rtl/cacheline_mem_arbiter.sv
// Shares the single physical-memory line port between the I-cache fill path
// and the D-cache fill/writeback path, one whole line transaction at a time.
// The data side has priority. Defining ARB_ANTI_STARVE_EN adds a streak
// counter that hands the port to the I-cache after MAX_D_STREAK consecutive
// D grants made while the I-cache was waiting.
module cacheline_mem_arbiter
    import mp3_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int LINE_W       = 256,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_read_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_resp_o,
    output logic [LINE_W-1:0] i_rdata_o,
    input  logic              d_read_i,
    input  logic              d_write_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [LINE_W-1:0] d_wdata_i,
    output logic              d_resp_o,
    output logic [LINE_W-1:0] d_rdata_o,
    output logic              pmem_read_o,
    output logic              pmem_write_o,
    output logic [ADDR_W-1:0] pmem_addr_o,
    output logic [LINE_W-1:0] pmem_wdata_o,
    input  logic              pmem_resp_i,
    input  logic [LINE_W-1:0] pmem_rdata_i
);

    if (MAX_D_STREAK < 1) begin : g_bad_streak
        $error("MAX_D_STREAK must be at least 1");
    end

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              dReq;
    logic              grantI;
    logic              grantD;
    logic              unusedAddrLsb;

`ifdef ARB_ANTI_STARVE_EN
    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                starve;

    assign starve = (streak_q == STREAK_W'(MAX_D_STREAK)) && i_read_i;
`endif

    assign dReq = d_read_i | d_write_i;

    // Grant decision in IDLE and capture of the winner's address, data and op.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        grantI  = 1'b0;
        grantD  = 1'b0;
`ifdef ARB_ANTI_STARVE_EN
        streak_d = streak_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef ARB_ANTI_STARVE_EN
                if (i_read_i && (starve || !dReq)) begin
`else
                if (i_read_i && !dReq) begin
`endif
                    grantI = 1'b1;
                end else if (dReq) begin
                    grantD = 1'b1;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grantD) begin
            state_d = SERVE_D;
            addr_d  = d_addr_i;
            wdata_d = d_wdata_i;
            write_d = d_write_i;
        end
        if (grantI) begin
            state_d = SERVE_I;
            addr_d  = i_addr_i;
            wdata_d = '0;
            write_d = 1'b0;
        end

`ifdef ARB_ANTI_STARVE_EN
        if (grantI) begin
            streak_d = '0;
        end else if (grantD) begin
            if (!i_read_i) begin
                streak_d = '0;
            end else if (streak_q != STREAK_W'(MAX_D_STREAK)) begin
                streak_d = streak_q + STREAK_W'(1);
            end
        end
`endif
    end

    // State register plus the transaction registers that drive pmem.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
`ifdef ARB_ANTI_STARVE_EN
            streak_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
`ifdef ARB_ANTI_STARVE_EN
            streak_q <= streak_d;
`endif
        end
    end

    // Flags a D request asking for both read and write; the write is served.
    always_ff @(posedge clk_i) begin
        if (!rst_i && grantD) begin
            assert (!(d_read_i && d_write_i))
                else $warning("d_read and d_write both high, serving as write");
        end
    end

    assign unusedAddrLsb = ^addr_q[LINE_OFFSET_W-1:0];

    assign pmem_addr_o  = {addr_q[ADDR_W-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
    assign pmem_wdata_o = wdata_q;
    assign pmem_read_o  = (state_q != IDLE) && !write_q;
    assign pmem_write_o = (state_q != IDLE) && write_q;

    assign i_resp_o  = pmem_resp_i && (state_q == SERVE_I);
    assign d_resp_o  = pmem_resp_i && (state_q == SERVE_D);
    assign i_rdata_o = (state_q == SERVE_I) ? pmem_rdata_i : '0;
    assign d_rdata_o = (state_q == SERVE_D) ? pmem_rdata_i : '0;

endmodule
